// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared types and constants for the tug-of-war input conditioner
package tug_pkg;

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    HELD
  } key_state_t;

  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/tug_key_channel.sv
// rtl/tug_key_channel.sv - one player key: synchronizer, optional debounce, press FSM
// Debounce counter is present only when TUG_INPUT_DEBOUNCE_EN is defined.
module tug_key_channel
  import tug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_p
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_warm;
  logic       w_lvl;
  logic       w_acc_lvl;
  key_state_t r_state;
  logic       r_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= KEY_RELEASED;
      r_sync2 <= KEY_RELEASED;
      r_warm  <= 2'b00;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
    end
  end

  assign w_lvl = ~r_sync2;

`ifdef TUG_INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_acc;

  // A full count means the previous DEBOUNCE_CYCLES samples all disagreed: flip now.
  assign w_acc_lvl = (r_cnt == CNT_MAX) ? ~r_acc : r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= 1'b0;
    end else begin
      r_acc <= w_acc_lvl;
      if (r_cnt == CNT_MAX || w_lvl == r_acc) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
`else
  assign w_acc_lvl = w_lvl;
`endif

  // The sync flops hold reset values for two edges; WAIT_REL must not trust them,
  // otherwise a key held through reset would look released and then pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT_REL;
      r_p     <= 1'b0;
    end else begin
      r_p <= 1'b0;
      case (r_state)
        WAIT_REL: if (r_warm[1] && !w_acc_lvl) r_state <= IDLE;
        IDLE: begin
          if (w_acc_lvl) begin
            r_state <= HELD;
            r_p     <= 1'b1;
          end
        end
        HELD:     if (!w_acc_lvl) r_state <= IDLE;
        default:  r_state <= WAIT_REL;
      endcase
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/tug_input_conditioner.sv
// rtl/tug_input_conditioner.sv - two-key press conditioner with same-cycle tie cancel
// Optional debounce enabled by defining TUG_INPUT_DEBOUNCE_EN.
module tug_input_conditioner
  import tug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  output logic l_press,
  output logic r_press,
  output logic tie
);

  logic w_p_l;
  logic w_p_r;
  logic r_l_press;
  logic r_r_press;
  logic r_tie;

  tug_key_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_l (
    .clk    (clk),
    .reset  (reset),
    .i_key_n(key_l_n),
    .o_p    (w_p_l)
  );

  tug_key_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_r (
    .clk    (clk),
    .reset  (reset),
    .i_key_n(key_r_n),
    .o_p    (w_p_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_l_press <= 1'b0;
      r_r_press <= 1'b0;
      r_tie     <= 1'b0;
    end else begin
      r_l_press <= w_p_l & ~w_p_r;
      r_r_press <= w_p_r & ~w_p_l;
      r_tie     <= w_p_l & w_p_r;
    end
  end

  assign l_press = r_l_press;
  assign r_press = r_r_press;
  assign tie     = r_tie;

endmodule

// File: tb/tb_tug_input_conditioner.sv
// tb/tb_tug_input_conditioner.sv - directed and random checks of tug_input_conditioner
module tb_tug_input_conditioner;

  localparam int DEB = 4;
`ifdef TUG_INPUT_DEBOUNCE_EN
  localparam int D_EFF = DEB;
`else
  localparam int D_EFF = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_l_n = 1'b1;
  logic key_r_n = 1'b1;
  logic l_press;
  logic r_press;
  logic tie;

  tug_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .key_l_n(key_l_n),
    .key_r_n(key_r_n),
    .l_press(l_press),
    .r_press(r_press),
    .tie    (tie)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_l, n_r, n_t, at_l, at_r, at_t, mn_l;

  // Reference: keys seen since reset, run length of disagreeing samples, armed/down flags.
  bit [1:0] hist[$];
  int run[2];
  bit acc[2], armed[2], down[2], p[2];
  bit e_l, e_r, e_t;

  task automatic model_edge(input bit rst, input bit [1:0] k);
    bit valid, lvl, nw;
    if (rst) begin
      hist.delete();
      for (int ch = 0; ch < 2; ch++) begin
        run[ch] = 0; acc[ch] = 0; armed[ch] = 0; down[ch] = 0; p[ch] = 0;
      end
      e_l = 0; e_r = 0; e_t = 0;
      return;
    end
    e_l = p[0] & ~p[1];
    e_r = p[1] & ~p[0];
    e_t = p[0] & p[1];
    valid = (hist.size() >= 2);
    for (int ch = 0; ch < 2; ch++) begin
      lvl = 1'b0;
      if (valid) lvl = ~hist[hist.size()-2][ch];
      if (D_EFF == 0) begin
        nw = lvl;
      end else if (run[ch] == D_EFF) begin
        nw = ~acc[ch];
        run[ch] = 0;
      end else begin
        nw = acc[ch];
        run[ch] = (lvl == acc[ch]) ? 0 : run[ch] + 1;
      end
      acc[ch] = nw;
      p[ch] = 0;
      if (!armed[ch]) begin
        if (valid && !nw) armed[ch] = 1;
      end else if (!down[ch]) begin
        if (nw) begin
          down[ch] = 1;
          p[ch] = 1;
        end
      end else if (!nw) begin
        down[ch] = 0;
      end
    end
    hist.push_back(k);
    if (hist.size() > 2) void'(hist.pop_front());
  endtask

  task automatic tick();
    bit r;
    bit [1:0] k;
    @(posedge clk);
    r = reset;
    k = {key_r_n, key_l_n};
    cyc++;
    model_edge(r, k);
    #1;
    checks++;
    assert ({l_press, r_press, tie} === {e_l, e_r, e_t})
    else begin
      errors++;
      $error("FAIL model cyc=%0d obs=%b exp=%b", cyc, {l_press, r_press, tie}, {e_l, e_r, e_t});
    end
    if (l_press === 1'b1) begin n_l++; at_l = cyc; end
    if (r_press === 1'b1) begin n_r++; at_r = cyc; end
    if (tie === 1'b1) begin n_t++; at_t = cyc; end
    if (e_l) mn_l++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    n_l = 0; n_r = 0; n_t = 0; at_l = -1; at_r = -1; at_t = -1; mn_l = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int t0;
    clr();
    reset = 1'b1;
    ticks(3);
    chk("reset_outputs", int'({l_press, r_press, tie}), 0);
    reset = 1'b0;
    ticks(5);

    // 1: single press, latency
    clr();
    key_l_n = 1'b0;
    t0 = cyc + 1;
    ticks(20);
    key_l_n = 1'b1;
    ticks(12);
    chk("t1_l_count", n_l, 1);
    chk("t1_latency", at_l - t0, 3 + D_EFF);
    chk("t1_r_count", n_r, 0);
    chk("t1_tie_count", n_t, 0);

    // 2: right key held through reset
    key_r_n = 1'b0;
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    clr();
    ticks(20);
    chk("t2_held_no_r", n_r, 0);
    key_r_n = 1'b1;
    ticks(10);
    clr();
    key_r_n = 1'b0;
    ticks(20);
    chk("t2_repress_r", n_r, 1);
    key_r_n = 1'b1;
    ticks(12);

    // 3: short and minimum-length presses
    clr();
    key_l_n = 1'b0;
    ticks(3);
    key_l_n = 1'b1;
    ticks(12);
    chk("t3_short_press", n_l, (D_EFF == 0) ? 1 : 0);
    clr();
    key_l_n = 1'b0;
    ticks(4);
    key_l_n = 1'b1;
    ticks(12);
    chk("t3_min_press", n_l, 1);

    // 4: same-edge tie, then one-cycle skew
    clr();
    key_l_n = 1'b0;
    key_r_n = 1'b0;
    t0 = cyc + 1;
    ticks(20);
    chk("t4_tie_count", n_t, 1);
    chk("t4_tie_latency", at_t - t0, 3 + D_EFF);
    chk("t4_tie_l_none", n_l, 0);
    chk("t4_tie_r_none", n_r, 0);
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    ticks(12);
    clr();
    key_l_n = 1'b0;
    tick();
    key_r_n = 1'b0;
    ticks(20);
    chk("t4_skew_l", n_l, 1);
    chk("t4_skew_r", n_r, 1);
    chk("t4_skew_gap", at_r - at_l, 1);
    chk("t4_skew_no_tie", n_t, 0);
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    ticks(12);

    // 5: reset lands on the edge that would register the pulse
    clr();
    key_l_n = 1'b0;
    ticks(3 + D_EFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(20);
    chk("t5_reset_kills_pulse", n_l, 0);
    key_l_n = 1'b1;
    ticks(12);
    clr();
    key_l_n = 1'b0;
    ticks(20);
    chk("t5_repress", n_l, 1);
    key_l_n = 1'b1;
    ticks(12);

    // 6: bouncing press
    clr();
    begin
      int left;
      int s;
      bit v;
      left = 12;
      v = 1'b1;
      while (left > 0) begin
        s = $urandom_range(1, 3);
        if (s > left) s = left;
        v = ~v;
        key_l_n = v;
        ticks(s);
        left -= s;
      end
    end
    key_l_n = 1'b0;
    ticks(20);
    chk("t6_bounce_model", n_l, mn_l);
`ifdef TUG_INPUT_DEBOUNCE_EN
    chk("t6_bounce_single", n_l, 1);
`endif
    key_l_n = 1'b1;
    ticks(12);

    // random segments on both keys, with occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      key_l_n = 1'($urandom_range(0, 1));
      key_r_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      ticks($urandom_range(1, 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
